demux32_14_buf: RTL and testbench

//  Buffered 1-to-4 demultiplexer for 32-bit words, the distributing

---
 rtl/demux32_14_buf_if.sv | 26 ++
 rtl/demux32_14_buf.sv | 99 +++++++++
 tb/tb_demux32_14_buf.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/demux32_14_buf_if.sv
// Handshake bundle for the buffered 1-to-4 32-bit demultiplexer.
// master: producer + consumers side; slave: the demux itself.
interface demux32_14_buf_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data0;
    logic [31:0] out_data1;
    logic [31:0] out_data2;
    logic [31:0] out_data3;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid,
        input  out_data0, out_data1, out_data2, out_data3
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid,
        output out_data0, out_data1, out_data2, out_data3
    );
endinterface

// File: rtl/demux32_14_buf.sv
// Buffered 1-to-4 demux: each word is queued in the FIFO picked by in_sel,
// and each of the four outputs drains its own FIFO via valid/ready.
// Ports: clk, rst_n (async active-low), bus (demux32_14_buf_if.slave):
//   in_valid/in_ready/in_data/in_sel producer side,
//   out_valid[3:0]/out_ready[3:0]/out_data0..3 consumer side.
// Option: DEMUX_PASSTHRU_EN gives zero-latency bypass into an empty FIFO.
module demux32_14_buf #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux32_14_buf_if.slave       bus
);
    logic [31:0] mem    [4][DEPTH];
    logic [AW-1:0] rd_ptr [4];
    logic [AW-1:0] wr_ptr [4];
    logic [AW:0]   cnt    [4];
    logic [31:0]   hold   [4];

    logic [3:0]  full;
    logic [3:0]  nempty;
    logic [3:0]  push;
    logic [3:0]  pop;
    logic [3:0]  byp;
    logic [3:0]  byp_take;
    logic [3:0]  valid;
    logic [31:0] dout [4];

    always_comb begin
        full     = '0;
        nempty   = '0;
        push     = '0;
        pop      = '0;
        byp      = '0;
        byp_take = '0;
        valid    = '0;
        for (int k = 0; k < 4; k++) begin
            full[k]   = (cnt[k] == (AW+1)'(DEPTH));
            nempty[k] = (cnt[k] != '0);
        end
        for (int k = 0; k < 4; k++) begin
            pop[k] = nempty[k] && bus.out_ready[k];
`ifdef DEMUX_PASSTHRU_EN
            // A word aimed at an empty FIFO is shown immediately; if the
            // consumer takes it now it never needs to be stored.
            byp[k] = bus.in_valid && (bus.in_sel == 2'(k)) && !nempty[k];
            byp_take[k] = byp[k] && bus.out_ready[k];
`endif
            push[k] = bus.in_valid && (bus.in_sel == 2'(k))
                      && !full[k] && !byp_take[k];
            valid[k] = nempty[k] || byp[k];
            if (nempty[k])
                dout[k] = mem[k][rd_ptr[k]];
            else if (byp[k])
                dout[k] = bus.in_data;
            else
                dout[k] = hold[k];
        end
    end

    assign bus.in_ready  = ~full[bus.in_sel];
    assign bus.out_valid = valid;
    assign bus.out_data0 = dout[0];
    assign bus.out_data1 = dout[1];
    assign bus.out_data2 = dout[2];
    assign bus.out_data3 = dout[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                rd_ptr[k] <= '0;
                wr_ptr[k] <= '0;
                cnt[k]    <= '0;
                hold[k]   <= '0;
                for (int j = 0; j < DEPTH; j++)
                    mem[k][j] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push[k]) begin
                    mem[k][wr_ptr[k]] <= bus.in_data;
                    wr_ptr[k] <= wr_ptr[k] + 1'b1;
                end
                // Keep the last delivered word visible once the FIFO drains.
                if (pop[k]) begin
                    hold[k]   <= mem[k][rd_ptr[k]];
                    rd_ptr[k] <= rd_ptr[k] + 1'b1;
                end else if (byp_take[k]) begin
                    hold[k] <= bus.in_data;
                end
                if (push[k] && !pop[k])
                    cnt[k] <= cnt[k] + 1'b1;
                else if (pop[k] && !push[k])
                    cnt[k] <= cnt[k] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_demux32_14_buf.sv
// Directed bench for demux32_14_buf: queue model plus literal checks.
// Prints one summary line with run/failed counts.
module tb_demux32_14_buf;
    localparam int DEPTH = 2;

    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    demux32_14_buf_if bus ();

    demux32_14_buf #(.DEPTH(DEPTH), .AW(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference: one queue per output plus the last word delivered.
    logic [31:0] q [4][$];
    logic [31:0] last [4];

    initial begin
        for (int k = 0; k < 4; k++) last[k] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 4; k++) begin
                    q[k].delete();
                    last[k] = '0;
                end
            end else begin
                int sz [4];
                int s;
                for (int k = 0; k < 4; k++) sz[k] = q[k].size();
                s = int'(bus.in_sel);
                for (int k = 0; k < 4; k++)
                    if (sz[k] != 0 && bus.out_ready[k])
                        last[k] = q[k].pop_front();
                if (bus.in_valid && sz[s] < DEPTH) begin
`ifdef DEMUX_PASSTHRU_EN
                    if (sz[s] == 0 && bus.out_ready[s])
                        last[s] = bus.in_data;
                    else
                        q[s].push_back(bus.in_data);
`else
                    q[s].push_back(bus.in_data);
`endif
                end
            end
        end
    end

    function automatic logic [31:0] dut_data(input int k);
        case (k)
            0: return bus.out_data0;
            1: return bus.out_data1;
            2: return bus.out_data2;
            default: return bus.out_data3;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                logic ev;
                logic [31:0] ed;
                ev = (q[k].size() != 0);
                ed = ev ? q[k][0] : last[k];
`ifdef DEMUX_PASSTHRU_EN
                if (!ev && bus.in_valid && int'(bus.in_sel) == k) begin
                    ev = 1'b1;
                    ed = bus.in_data;
                end
`endif
                chk($sformatf("model valid%0d", k), 32'(bus.out_valid[k]),
                    32'(ev));
                chk($sformatf("model data%0d", k), dut_data(k), ed);
            end
            chk("model in_ready", 32'(bus.in_ready),
                32'(q[int'(bus.in_sel)].size() < DEPTH));
        end
    end

    task automatic drive(input logic v, input logic [1:0] s,
                         input logic [31:0] d, input logic [3:0] r);
        #1;
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
    endtask

    task automatic step(input logic v, input logic [1:0] s,
                        input logic [31:0] d, input logic [3:0] r);
        drive(v, s, d, r);
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid  = 0;
        bus.in_sel    = 0;
        bus.in_data   = 0;
        bus.out_ready = 0;
        #1;
        chk("reset valid", 32'(bus.out_valid), 32'h0);
        chk("reset ready", 32'(bus.in_ready), 32'h1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        @(negedge clk);

        // Routing, one cycle latency
        step(1, 0, 32'hA0, 4'hF);
        chk("rt v0", 32'(bus.out_valid), 32'h1);
        chk("rt d0", bus.out_data0, 32'hA0);
        step(1, 1, 32'hB1, 4'hF);
        chk("rt v1", 32'(bus.out_valid), 32'h2);
        chk("rt d1", bus.out_data1, 32'hB1);
        chk("rt hold0", bus.out_data0, 32'hA0);
        step(1, 2, 32'hC2, 4'hF);
        chk("rt v2", 32'(bus.out_valid), 32'h4);
        chk("rt d2", bus.out_data2, 32'hC2);
        step(1, 3, 32'hD3, 4'hF);
        chk("rt v3", 32'(bus.out_valid), 32'h8);
        chk("rt d3", bus.out_data3, 32'hD3);
        step(0, 0, 32'h0, 4'hF);
        chk("rt idle", 32'(bus.out_valid), 32'h0);
        chk("rt hold3", bus.out_data3, 32'hD3);

        // Full FIFO2, other destination still accepted
        step(1, 2, 32'hC0, 4'b1011);
        step(1, 2, 32'hC1, 4'b1011);
        drive(1, 2, 32'hCC, 4'b1011);
        #1 chk("full stall", 32'(bus.in_ready), 32'h0);
        @(negedge clk);
        drive(1, 0, 32'hE0, 4'b1011);
        #1 chk("full other", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        chk("full valid", 32'(bus.out_valid), 32'h5);
        chk("full head2", bus.out_data2, 32'hC0);
        step(0, 0, 32'h0, 4'hF);
        chk("full next2", bus.out_data2, 32'hC1);
        step(0, 0, 32'h0, 4'hF);
        chk("full drain", 32'(bus.out_valid), 32'h0);

        // Full + pop same cycle on FIFO1
        step(1, 1, 32'd1, 4'b1101);
        step(1, 1, 32'd2, 4'b1101);
        drive(1, 1, 32'd3, 4'hF);
        #1 chk("fp reject", 32'(bus.in_ready), 32'h0);
        @(negedge clk);
        chk("fp head2", bus.out_data1, 32'd2);
        chk("fp ready", 32'(bus.in_ready), 32'h1);
        step(1, 1, 32'd3, 4'hF);
        chk("fp head3", bus.out_data1, 32'd3);
        step(0, 0, 32'h0, 4'hF);
        chk("fp empty", 32'(bus.out_valid), 32'h0);

        // Wrap: ten back-to-back words through FIFO3
        for (int i = 0; i < 10; i++) begin
            step(1, 3, 32'(i), 4'hF);
            chk($sformatf("wrap v%0d", i), 32'(bus.out_valid[3]), 32'h1);
            chk($sformatf("wrap d%0d", i), bus.out_data3, 32'(i));
        end
        step(0, 0, 32'h0, 4'hF);
        chk("wrap end", 32'(bus.out_valid), 32'h0);

        // Reset mid-burst
        step(1, 0, 32'h55, 4'h0);
        step(1, 1, 32'h66, 4'h0);
        #1 rst_n = 0;
        #1;
        chk("rst valid", 32'(bus.out_valid), 32'h0);
        chk("rst d0", bus.out_data0, 32'h0);
        chk("rst d1", bus.out_data1, 32'h0);
        chk("rst d3", bus.out_data3, 32'h0);
        @(negedge clk);
        drive(0, 1, 32'h0, 4'h0);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst empty", 32'(bus.out_valid), 32'h0);

`ifdef DEMUX_PASSTHRU_EN
        drive(1, 0, 32'h1234, 4'h1);
        #1 chk("pt data", bus.out_data0, 32'h1234);
        chk("pt valid", 32'(bus.out_valid[0]), 32'h1);
        @(negedge clk);
        drive(0, 0, 32'h0, 4'h0);
        #1 chk("pt nocount", 32'(bus.out_valid[0]), 32'h0);
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
